spi_master_rx_param: RTL and testbench
======================================

SPI_MASTER_RX_PARAM -- requirements
Module: spi_master_rx_param

Interface
REQ-001 Parameter DATA_W, default 8, frame length in bits; legal 1..32.
REQ-002 Parameter SCK_HALF, default 20, clk cycles per SCK half-period; legal >= 2.
REQ-003 Parameter CPOL, default 0, SCK idle level.
REQ-004 Parameter CPHA, default 0: 0 = sample MISO on leading SCK edge, 1 = on trailing edge.
REQ-005 Parameter LSB_FIRST, default 0: 0 = first received bit lands in data[DATA_W-1], 1 = in data[0].
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 miso  input  1  serial data from slave.
REQ-009 get  input  1  level request; high = run frames continuously.
REQ-010 data  output  DATA_W  last completed received word.
REQ-011 ss  output  1  slave select, active low.
REQ-012 sck  output  1  serial clock.
REQ-013 busy  output  1  high while a frame or its inter-frame gap is in progress.
REQ-014 rdy  output  1  one-cycle pulse when data is updated.

Function
REQ-015 States: IDLE, SHIFT, GAP; all outputs registered.
REQ-016 IDLE: ss=1, sck=CPOL, busy=0; on edge T0 with get=1 -> SHIFT, ss=0, busy=1, bit counter=0.
REQ-017 SHIFT: SCK toggles at T0+k*SCK_HALF, k=1..2*DATA_W; odd k = leading edge, even k = trailing edge; sck equals CPOL after k=2*DATA_W.
REQ-018 MISO sampled at the clk edge producing a leading edge (CPHA=0) or trailing edge (CPHA=1); exactly DATA_W samples per frame.
REQ-019 At T0+2*DATA_W*SCK_HALF: data <= assembled word, rdy=1 for exactly one cycle, ss=1, -> GAP.
REQ-020 GAP: ss=1, sck=CPOL, busy=1 for SCK_HALF cycles; then get=1 -> SHIFT directly (busy stays 1, new T0), else -> IDLE (busy=0).
REQ-021 get deasserted mid-frame: current frame completes, rdy still pulses, then GAP then IDLE.
REQ-022 data holds its value between rdy pulses; partial frames never visible on data.
REQ-023 ss low duration per frame exactly 2*DATA_W*SCK_HALF cycles; ss-high gap between back-to-back frames exactly SCK_HALF cycles.

Reset
REQ-024 rst high immediately (asynchronously): state=IDLE, ss=1, sck=CPOL, busy=0, rdy=0, data=0, counters=0.
REQ-025 Reset mid-frame aborts the frame: no rdy, data stays 0; first frame after release starts only on get=1 sampled with rst low.

Configuration
REQ-026 Macro SPI_MASTER_RX_PARAM_DBG_EN: when defined, extra outputs _dbg_cs (2 bits, state encoding IDLE=0, SHIFT=1, GAP=2), _dbg_idx (6 bits, bits received in current frame) and _dbg_buff (DATA_W bits, shift register) SHALL be present after rdy; when undefined these ports and their logic SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-027 DATA_W=8, SCK_HALF=20, mode 0, slave shifts 8'hA5 MSB-first, get pulsed high until rdy -> data=8'hA5, single rdy pulse 320 cycles after ss falls, ss low 320 cycles, busy drops 20 cycles after rdy.
REQ-028 Same config, get held high, slave sends 8'h3C then 8'hC3 -> two rdy pulses 340 cycles apart, data 8'h3C then 8'hC3, ss high exactly 20 cycles between frames, busy never drops.
REQ-029 CPOL=1, CPHA=1, LSB_FIRST=1, slave sends bit sequence 1,0,0,0,0,0,0,0 -> sck idles high, data=8'h01.
REQ-030 DATA_W=16, SCK_HALF=4, mode 0, slave sends 16'hBEEF -> data=16'hBEEF, rdy 128 cycles after ss falls.
REQ-031 rst asserted at 150 cycles into an 8'hFF frame -> ss=1, sck=CPOL, busy=0 same cycle, no rdy, data=0; next get frame receives correctly.
REQ-032 Build with and without SPI_MASTER_RX_PARAM_DBG_EN running REQ-027 -> identical data/ss/sck/busy/rdy traces; with macro _dbg_idx counts 0..8.

Source files
------------

// File: rtl/spi_master_rx_param_if.sv
// Signal bundle between the SPI receive master and its slave/consumer side.
// master modport is the controller's view; slave modport is the device + word consumer.
interface spi_master_rx_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic              miso;
  logic              get;
  logic [DATA_W-1:0] data;
  logic              ss;
  logic              sck;
  logic              busy;
  logic              rdy;

  modport master (
    input  miso,
    input  get,
    output data,
    output ss,
    output sck,
    output busy,
    output rdy
  );

  modport slave (
    output miso,
    output get,
    input  data,
    input  ss,
    input  sck,
    input  busy,
    input  rdy
  );
endinterface

// File: rtl/spi_master_rx_param.sv
// SPI receive master: frames run while get is high; data/rdy update 2*DATA_W*SCK_HALF cycles after ss falls, no backpressure (rdy is a strobe).
// Define SPI_MASTER_RX_PARAM_DBG_EN to add dbg_cs_o / dbg_idx_o / dbg_buff_o observation ports.
module spi_master_rx_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SCK_HALF  = 20,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  spi_master_rx_param_if.master bus
`ifdef SPI_MASTER_RX_PARAM_DBG_EN
  ,
  output logic [1:0]            dbg_cs_o,
  output logic [5:0]            dbg_idx_o,
  output logic [DATA_W-1:0]     dbg_buff_o
`endif
);

  localparam int unsigned   CW        = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(SCK_HALF - 1);
  localparam logic [6:0]    LAST_EDGE = 7'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [6:0]        edge_q, edge_d;
  logic [DATA_W-1:0] buff_q, buff_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ss_q, ss_d;
  logic              sck_q, sck_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
  logic              half_done;
  logic              sample;
  logic [DATA_W-1:0] shifted;

  assign half_done = (cnt_q == HALF_LAST);
  // edge_q counts SCK toggles already made; even count means the next toggle is a leading edge
  assign sample    = (edge_q[0] == CPHA);

  always_comb begin
    shifted = '0;
    if (LSB_FIRST) begin
      shifted = (buff_q >> 1) | (DATA_W'(bus.miso) << (DATA_W - 1));
    end else begin
      shifted = (buff_q << 1) | DATA_W'(bus.miso);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    buff_d  = buff_q;
    data_d  = data_q;
    ss_d    = ss_q;
    sck_d   = sck_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ss_d   = 1'b1;
        sck_d  = CPOL;
        busy_d = 1'b0;
        if (bus.get) begin
          state_d = SHIFT;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          edge_d  = '0;
        end
      end
      SHIFT: begin
        if (half_done) begin
          cnt_d  = '0;
          sck_d  = ~sck_q;
          edge_d = edge_q + 7'd1;
          if (sample) begin
            buff_d = shifted;
          end
          // buff_d already includes a trailing-edge sample taken on this same final edge
          if (edge_q == LAST_EDGE) begin
            data_d  = buff_d;
            rdy_d   = 1'b1;
            ss_d    = 1'b1;
            sck_d   = CPOL;
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (half_done) begin
          cnt_d = '0;
          if (bus.get) begin
            state_d = SHIFT;
            ss_d    = 1'b0;
            edge_d  = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      buff_q  <= '0;
      data_q  <= '0;
      ss_q    <= 1'b1;
      sck_q   <= CPOL;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      buff_q  <= buff_d;
      data_q  <= data_d;
      ss_q    <= ss_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.data = data_q;
  assign bus.ss   = ss_q;
  assign bus.sck  = sck_q;
  assign bus.busy = busy_q;
  assign bus.rdy  = rdy_q;

`ifdef SPI_MASTER_RX_PARAM_DBG_EN
  // Received-bit count follows from the toggle count and which edge samples
  assign dbg_cs_o   = state_q;
  assign dbg_idx_o  = CPHA ? 6'(edge_q >> 1) : 6'((edge_q + 7'd1) >> 1);
  assign dbg_buff_o = buff_q;
`endif

endmodule

// File: tb/tb_spi_master_rx_param.sv
// Directed bench: three parameterisations (mode 0 8-bit, mode 3 LSB-first, 16-bit fast) with behavioural SPI slaves.
// Expected words and cycle distances are hand-derived constants.
module tb_spi_master_rx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_rx_param_if #(.DATA_W(8))  if0 ();
  spi_master_rx_param_if #(.DATA_W(8))  if1 ();
  spi_master_rx_param_if #(.DATA_W(16)) if2 ();

`ifdef SPI_MASTER_RX_PARAM_DBG_EN
  logic [1:0]  dbg_cs0, dbg_cs1, dbg_cs2;
  logic [5:0]  dbg_idx0, dbg_idx1, dbg_idx2;
  logic [7:0]  dbg_buff0, dbg_buff1;
  logic [15:0] dbg_buff2;
`endif

  spi_master_rx_param #(.DATA_W(8), .SCK_HALF(20), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .bus(if0)
`ifdef SPI_MASTER_RX_PARAM_DBG_EN
    , .dbg_cs_o(dbg_cs0), .dbg_idx_o(dbg_idx0), .dbg_buff_o(dbg_buff0)
`endif
  );

  spi_master_rx_param #(.DATA_W(8), .SCK_HALF(20), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .bus(if1)
`ifdef SPI_MASTER_RX_PARAM_DBG_EN
    , .dbg_cs_o(dbg_cs1), .dbg_idx_o(dbg_idx1), .dbg_buff_o(dbg_buff1)
`endif
  );

  spi_master_rx_param #(.DATA_W(16), .SCK_HALF(4), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u2 (
    .clk_i(clk), .rst_i(rst), .bus(if2)
`ifdef SPI_MASTER_RX_PARAM_DBG_EN
    , .dbg_cs_o(dbg_cs2), .dbg_idx_o(dbg_idx2), .dbg_buff_o(dbg_buff2)
`endif
  );

  // Mode-0 slaves present the MSB when ss falls and shift on each falling SCK
  logic [7:0]  tx0 [0:7];
  int          fc0 = 0;
  logic [7:0]  sh0 = '0;
  logic        p_ss0 = 1'b1, p_sck0 = 1'b0;
  always @(negedge clk) begin
    if (p_ss0 && !if0.ss) begin
      if0.miso <= tx0[fc0[2:0]][7];
      sh0      <= tx0[fc0[2:0]] << 1;
      fc0      <= fc0 + 1;
    end else if (!if0.ss && p_sck0 && !if0.sck) begin
      if0.miso <= sh0[7];
      sh0      <= sh0 << 1;
    end
    p_ss0  <= if0.ss;
    p_sck0 <= if0.sck;
  end

  logic [15:0] tx2 = 16'hBEEF;
  logic [15:0] sh2 = '0;
  logic        p_ss2 = 1'b1, p_sck2 = 1'b0;
  always @(negedge clk) begin
    if (p_ss2 && !if2.ss) begin
      if2.miso <= tx2[15];
      sh2      <= tx2 << 1;
    end else if (!if2.ss && p_sck2 && !if2.sck) begin
      if2.miso <= sh2[15];
      sh2      <= sh2 << 1;
    end
    p_ss2  <= if2.ss;
    p_sck2 <= if2.sck;
  end

  // Mode-3 slave: new bit on each falling (leading) SCK edge, bit order 1,0,0,0,0,0,0,0
  logic [7:0] tx1 = 8'h80;
  logic [7:0] sh1 = '0;
  logic       p_ss1 = 1'b1, p_sck1 = 1'b1;
  always @(negedge clk) begin
    if (p_ss1 && !if1.ss) begin
      if1.miso <= 1'b0;
      sh1      <= tx1;
    end else if (!if1.ss && p_sck1 && !if1.sck) begin
      if1.miso <= sh1[7];
      sh1      <= sh1 << 1;
    end
    p_ss1  <= if1.ss;
    p_sck1 <= if1.sck;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t_fall[$], t_rise[$], t_rdy[$], t_bfall[$], d_rdy[$];
  logic s_ss, s_sck, s_busy, s_rdy, p_ss, p_busy;
  logic [31:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int which);
    case (which)
      0:       begin s_ss = if0.ss; s_sck = if0.sck; s_busy = if0.busy; s_rdy = if0.rdy; s_data = 32'(if0.data); end
      1:       begin s_ss = if1.ss; s_sck = if1.sck; s_busy = if1.busy; s_rdy = if1.rdy; s_data = 32'(if1.data); end
      default: begin s_ss = if2.ss; s_sck = if2.sck; s_busy = if2.busy; s_rdy = if2.rdy; s_data = 32'(if2.data); end
    endcase
  endtask

  task automatic begin_scn(input int which);
    t_fall.delete(); t_rise.delete(); t_rdy.delete(); t_bfall.delete(); d_rdy.delete();
    sample(which);
    p_ss   = s_ss;
    p_busy = s_busy;
  endtask

  task automatic step(input int which);
    tick();
    cyc++;
    sample(which);
    if (p_ss && !s_ss) t_fall.push_back(cyc);
    if (!p_ss && s_ss) t_rise.push_back(cyc);
    if (p_busy && !s_busy) t_bfall.push_back(cyc);
    if (s_rdy) begin
      t_rdy.push_back(cyc);
      d_rdy.push_back(int'(s_data));
    end
    p_ss   = s_ss;
    p_busy = s_busy;
  endtask

  task automatic run_until(input string tag, input int which, input int nrdy, input int budget);
    int i = 0;
    while (t_rdy.size() < nrdy && i < budget) begin
      step(which);
      i++;
    end
    chk(tag, t_rdy.size(), nrdy);
  endtask

  task automatic run_idle(input string tag, input int which, input int budget);
    int i = 0;
    while (t_bfall.size() == 0 && i < budget) begin
      step(which);
      i++;
    end
    chk(tag, t_bfall.size(), 1);
  endtask

  initial begin
    tx0[0] = 8'hA5; tx0[1] = 8'h3C; tx0[2] = 8'hC3; tx0[3] = 8'hFF;
    tx0[4] = 8'h96; tx0[5] = 8'h00; tx0[6] = 8'h00; tx0[7] = 8'h00;
    if0.get = 1'b0; if1.get = 1'b0; if2.get = 1'b0;
    repeat (3) tick();
    chk("rst_ss",   32'(if0.ss), 1);
    chk("rst_sck",  32'(if0.sck), 0);
    chk("rst_busy", 32'(if0.busy), 0);
    chk("rst_rdy",  32'(if0.rdy), 0);
    chk("rst_data", 32'(if0.data), 0);
    chk("rst_sck_cpol1", 32'(if1.sck), 1);
`ifdef SPI_MASTER_RX_PARAM_DBG_EN
    chk("rst_dbg_idx", 32'(dbg_idx0), 0);
`endif
    rst = 1'b0;
    repeat (3) tick();

    // single frame A5, get dropped once rdy is seen
    begin_scn(0);
    if0.get = 1'b1;
    run_until("a5_rdy_seen", 0, 1, 400);
`ifdef SPI_MASTER_RX_PARAM_DBG_EN
    chk("a5_dbg_cs",   32'(dbg_cs0), 2);
    chk("a5_dbg_idx",  32'(dbg_idx0), 8);
    chk("a5_dbg_buff", 32'(dbg_buff0), 32'h A5);
`endif
    if0.get = 1'b0;
    run_idle("a5_busy_fall", 0, 100);
    repeat (5) step(0);
    chk("a5_data",      32'(qget(d_rdy, 0)), 32'hA5);
    chk("a5_rdy_lat",   32'(qget(t_rdy, 0) - qget(t_fall, 0)), 320);
    chk("a5_ss_low",    32'(qget(t_rise, 0) - qget(t_fall, 0)), 320);
    chk("a5_busy_tail", 32'(qget(t_bfall, 0) - qget(t_rdy, 0)), 20);
    chk("a5_one_rdy",   32'(t_rdy.size()), 1);
    chk("a5_hold",      32'(if0.data), 32'hA5);

    // back-to-back 3C, C3 with get held high
    begin_scn(0);
    if0.get = 1'b1;
    run_until("b2b_rdy_seen", 0, 2, 900);
    if0.get = 1'b0;
    run_idle("b2b_busy_fall", 0, 100);
    chk("b2b_data0",    32'(qget(d_rdy, 0)), 32'h3C);
    chk("b2b_data1",    32'(qget(d_rdy, 1)), 32'hC3);
    chk("b2b_rdy_gap",  32'(qget(t_rdy, 1) - qget(t_rdy, 0)), 340);
    chk("b2b_ss_gap",   32'(qget(t_fall, 1) - qget(t_rise, 0)), 20);
    chk("b2b_busy_end", 32'(qget(t_bfall, 0) - qget(t_rdy, 1)), 20);

    // CPOL=1, CPHA=1, LSB first
    begin_scn(1);
    if1.get = 1'b1;
    run_until("m3_rdy_seen", 1, 1, 400);
    if1.get = 1'b0;
    chk("m3_data",     32'(qget(d_rdy, 0)), 32'h01);
    chk("m3_sck_end",  32'(if1.sck), 1);
    chk("m3_rdy_lat",  32'(qget(t_rdy, 0) - qget(t_fall, 0)), 320);
    run_idle("m3_busy_fall", 1, 100);
    chk("m3_sck_idle", 32'(if1.sck), 1);

    // 16-bit word, SCK_HALF=4
    begin_scn(2);
    if2.get = 1'b1;
    run_until("w16_rdy_seen", 2, 1, 300);
    if2.get = 1'b0;
    chk("w16_data",    32'(qget(d_rdy, 0)), 32'hBEEF);
    chk("w16_rdy_lat", 32'(qget(t_rdy, 0) - qget(t_fall, 0)), 128);
    run_idle("w16_busy_fall", 2, 50);

    // reset 150 cycles into an FF frame, then a clean frame
    begin_scn(0);
    if0.get = 1'b1;
    repeat (151) step(0);
    chk("abort_fall_seen", 32'(t_fall.size()), 1);
    chk("abort_mid_ss",    32'(if0.ss), 0);
    chk("abort_mid_sck",   32'(if0.sck), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ss",   32'(if0.ss), 1);
    chk("abort_sck",  32'(if0.sck), 0);
    chk("abort_busy", 32'(if0.busy), 0);
    chk("abort_rdy",  32'(if0.rdy), 0);
    chk("abort_data", 32'(if0.data), 0);
    if0.get = 1'b0;
    begin_scn(0);
    repeat (3) step(0);
    rst = 1'b0;
    repeat (5) step(0);
    chk("abort_no_frame", 32'(t_fall.size()), 0);
    chk("abort_no_rdy",   32'(t_rdy.size()), 0);
    chk("abort_data_hold", 32'(if0.data), 0);
    if0.get = 1'b1;
    run_until("post_rst_rdy_seen", 0, 1, 400);
    if0.get = 1'b0;
    chk("post_rst_data", 32'(qget(d_rdy, 0)), 32'h96);
    chk("post_rst_lat",  32'(qget(t_rdy, 0) - qget(t_fall, 0)), 320);
    run_idle("post_rst_busy_fall", 0, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
